// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch front end.
package rv_fetch_pkg;

   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;
   localparam logic [ILEN-1:0] PC_STEP = 32'd4;

   // One buffered fetch result: the instruction word and its access-fault flag.
   typedef struct packed {
      logic [ILEN-1:0] data;
      logic err;
   } fetch_entry_t;

   // RUN fetches normally; FAULT parks the front end until a good redirect.
   typedef enum logic {
      ST_RUN = 1'b0,
      ST_FAULT = 1'b1
   } fetch_state_t;

   // RV32I fetch addresses must be word aligned.
   function automatic logic is_aligned(input logic [1:0] low_bits);
      return low_bits == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched words until decode consumes them.
// A flush empties it in one cycle and overrides any push or pop that cycle.
module fetch_fifo
   import rv_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input logic clk,
   input logic rst_n,
   input logic push,
   input fetch_entry_t push_entry,
   input logic pop,
   input logic flush,
   output fetch_entry_t head,
   output logic empty,
   output logic [CW-1:0] count
);

   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic full;
   logic do_push;
   logic do_pop;

   assign empty = (count == '0);
   assign full = (count == CW'(DEPTH));
   assign do_pop = pop & ~flush & ~empty;
   assign do_push = push & ~flush & (~full | do_pop);
   assign head = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch front end: owns the PC, issues credit-limited word requests,
// buffers in-order responses for decode, handles redirects and fetch faults.
module instruction_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int DEPTH = 2
) (
   input logic clk,
   input logic rst_n,
   output logic imem_req_valid,
   input logic imem_req_ready,
   output logic [ILEN-1:0] imem_req_addr,
   input logic imem_rsp_valid,
   input logic [ILEN-1:0] imem_rsp_data,
   input logic imem_rsp_err,
   input logic redirect_valid,
   input logic [ILEN-1:0] redirect_pc,
   output logic inst_valid,
   input logic inst_ready,
   output logic [ILEN-1:0] instruction_code,
   output logic [ILEN-1:0] inst_pc,
   output logic fetch_fault,
   output logic [ILEN-1:0] fault_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t state_q;
   fetch_state_t state_d;
   logic [ILEN-1:0] pc_q;
   logic [ILEN-1:0] head_pc_q;
   logic [ILEN-1:0] fault_pc_q;
   logic [ILEN-1:0] fault_pc_d;
   logic [CW-1:0] outstanding_q;
   logic [CW-1:0] discard_q;
   logic [CW-1:0] fifo_count;
   logic [CW:0] in_use;
   logic fetch_en_q;
   logic credit_ok;
   logic req_fire;
   logic fifo_empty;
   logic head_fault;
   logic pop;
   logic push;
   fetch_entry_t head_entry;
   fetch_entry_t rsp_entry;

   // Requests in flight plus words buffered may never exceed the buffer size,
   // so every response is guaranteed a slot.
   assign in_use = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign credit_ok = (in_use < (CW + 1)'(DEPTH));
   assign imem_req_valid = fetch_en_q & (state_q == ST_RUN) & ~redirect_valid & credit_ok;
   assign imem_req_addr = pc_q;
   assign req_fire = imem_req_valid & imem_req_ready;

   // Responses are dropped while stale ones are still draining or when a
   // redirect lands in the same cycle.
   assign push = imem_rsp_valid & (discard_q == '0) & ~redirect_valid;
   assign rsp_entry = '{data: imem_rsp_data, err: imem_rsp_err};

   assign head_fault = (state_q == ST_RUN) & ~fifo_empty & head_entry.err;
   assign inst_valid = (state_q == ST_RUN) & ~fifo_empty & ~head_entry.err;
   assign instruction_code = inst_valid ? head_entry.data : '0;
   assign inst_pc = head_pc_q;
   assign pop = inst_valid & inst_ready & ~redirect_valid;

   assign fetch_fault = (state_q == ST_FAULT) | head_fault;
   assign fault_pc = head_fault ? head_pc_q : fault_pc_q;

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(push),
      .push_entry(rsp_entry),
      .pop(pop),
      .flush(redirect_valid),
      .head(head_entry),
      .empty(fifo_empty),
      .count(fifo_count)
   );

   // Hold off the first request until the cycle after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_en_q <= 1'b0;
      end else begin
         fetch_en_q <= 1'b1;
      end
   end

   // Fetch PC and head PC: a redirect reloads both, otherwise each steps by a word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
         head_pc_q <= RESET_PC;
      end else if (redirect_valid) begin
         pc_q <= redirect_pc;
         head_pc_q <= redirect_pc;
      end else begin
         if (req_fire) begin
            pc_q <= pc_q + PC_STEP;
         end
         if (pop) begin
            head_pc_q <= head_pc_q + PC_STEP;
         end
      end
   end

   // Outstanding request count, and how many of those are stale; after a
   // redirect everything still in flight is stale, which also covers the
   // case of a redirect arriving while older discards are pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_q <= '0;
         discard_q <= '0;
      end else begin
         outstanding_q <= outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
         if (redirect_valid) begin
            discard_q <= outstanding_q - CW'(imem_rsp_valid);
         end else if (imem_rsp_valid && (discard_q != '0)) begin
            discard_q <= discard_q - CW'(1);
         end
      end
   end

   // Fault state register and the sticky faulting PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         fault_pc_q <= '0;
      end else begin
         state_q <= state_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   // Redirect takes priority: aligned targets resume fetch, misaligned ones fault;
   // otherwise an erroring head entry parks the unit in FAULT.
   always_comb begin
      state_d = state_q;
      fault_pc_d = fault_pc_q;
      if (redirect_valid) begin
         if (is_aligned(redirect_pc[1:0])) begin
            state_d = ST_RUN;
         end else begin
            state_d = ST_FAULT;
            fault_pc_d = redirect_pc;
         end
      end else if (head_fault) begin
         state_d = ST_FAULT;
         fault_pc_d = head_pc_q;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory model with in-order
// random-latency responses, program-order reference for the decode stream.
module tb_instruction_fetch_unit;
   import rv_fetch_pkg::*;

   localparam int DEPTH = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic imem_req_valid;
   logic imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic imem_rsp_err = 1'b0;
   logic redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic inst_valid;
   logic inst_ready = 1'b0;
   logic [31:0] instruction_code;
   logic [31:0] inst_pc;
   logic fetch_fault;
   logic [31:0] fault_pc;

   instruction_fetch_unit #(
      .RESET_PC(RESET_PC),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .imem_rsp_err(imem_rsp_err),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .instruction_code(instruction_code),
      .inst_pc(inst_pc),
      .fetch_fault(fetch_fault),
      .fault_pc(fault_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int due;
   } pend_t;

   typedef struct {
      bit redir;
      logic [31:0] rpc;
      bit exp_req_valid;
      logic [31:0] exp_req_addr;
      bit exp_fault;
      logic [31:0] exp_fault_pc;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_due = 0;
   int min_lat = 1;
   int max_lat = 1;
   int req_total = 0;
   int pop_count = 0;
   bit err_en = 1'b0;
   logic [31:0] err_addr = '0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] exp_req_pc = RESET_PC;
   pend_t pend[$];
   vec_t vecs[11];

   // Memory contents: a distinctive non-zero word per address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ((a ^ 32'h1357_9BDF) * 32'd2654435761) | 32'h1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // First half of a cycle: drive the memory response, then observe at the
   // falling edge and update the reference model.
   task automatic tick_pre();
      pend_t p;
      int lat;
      int due;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data = mem_word(pend[0].addr);
         imem_rsp_err = err_en && (pend[0].addr == err_addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data = '0;
         imem_rsp_err = 1'b0;
      end
      @(negedge clk);
      if (!inst_valid) check("code_zero_when_idle", instruction_code, 32'h0);
      if (redirect_valid) check("no_req_during_redirect", {31'h0, imem_req_valid}, 32'h0);
      if (inst_valid && !redirect_valid) begin
         check("head_pc", inst_pc, exp_pc);
         check("head_code", instruction_code, mem_word(exp_pc));
         if (inst_ready) begin
            exp_pc = exp_pc + 32'd4;
            pop_count++;
         end
      end
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
      if (imem_req_valid && imem_req_ready) begin
         exp_req_pc = exp_req_pc + 32'd4;
         req_total++;
         lat = $urandom_range(max_lat, min_lat);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         p.addr = imem_req_addr;
         p.due = due;
         pend.push_back(p);
      end
      if (imem_rsp_valid) void'(pend.pop_front());
      if (redirect_valid) begin
         exp_pc = redirect_pc;
         exp_req_pc = redirect_pc;
      end
      check("outstanding_bound", 32'(pend.size() <= DEPTH), 32'h1);
   endtask

   task automatic tick_post();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic tick();
      tick_pre();
      tick_post();
   endtask

   task automatic reset_model();
      pend.delete();
      exp_pc = RESET_PC;
      exp_req_pc = RESET_PC;
      req_total = 0;
      pop_count = 0;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      inst_ready = 1'b0;
      imem_req_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      reset_model();
      repeat (2) @(posedge clk);
      cyc += 2;
      last_due = cyc;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus(input bit rv, input logic [31:0] rpc, input bit rr, input bit ir);
      redirect_valid = rv;
      redirect_pc = rpc;
      imem_req_ready = rr;
      inst_ready = ir;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      check($sformatf("vec%0d_req_valid", idx), {31'h0, imem_req_valid}, {31'h0, v.exp_req_valid});
      if (v.exp_req_valid) check($sformatf("vec%0d_req_addr", idx), imem_req_addr, v.exp_req_addr);
      check($sformatf("vec%0d_fetch_fault", idx), {31'h0, fetch_fault}, {31'h0, v.exp_fault});
      if (v.exp_fault) check($sformatf("vec%0d_fault_pc", idx), fault_pc, v.exp_fault_pc);
      check($sformatf("vec%0d_inst_valid", idx), {31'h0, inst_valid}, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      vecs[0] = '{1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0};
      vecs[2] = '{1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b0, 32'h0};
      vecs[3] = '{1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 32'h0};
      vecs[4] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0102};
      vecs[5] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0102};
      vecs[6] = '{1'b1, 32'h103, 1'b0, 32'h0, 1'b1, 32'h0000_0102};
      vecs[7] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0103};
      vecs[8] = '{1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 32'h0000_0103};
      vecs[9] = '{1'b0, 32'h0, 1'b1, 32'h0000_0020, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 32'h0, 1'b1, 32'h0000_0020, 1'b0, 32'h0};

      // Reset values while rst_n is held low.
      #2;
      check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      check("rst_code", instruction_code, 32'h0);
      check("rst_inst_pc", inst_pc, RESET_PC);
      check("rst_fetch_fault", {31'h0, fetch_fault}, 32'h0);
      check("rst_fault_pc", fault_pc, 32'h0);

      // Redirect and misaligned-fault vectors with memory never accepting.
      do_reset();
      tick();
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].redir, vecs[i].rpc, 1'b0, 1'b0);
         tick_pre();
         checkOutput(vecs[i], i);
         tick_post();
      end
      redirect_valid = 1'b0;

      // Streaming from reset with one-cycle memory latency.
      do_reset();
      min_lat = 1;
      max_lat = 1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      repeat (10) tick();
      base = pop_count;
      repeat (30) tick();
      check("stream_throughput", 32'(pop_count - base >= 18), 32'h1);

      // Decode stall: credits cap outstanding plus buffered words.
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_credit", 32'(req_total - pop_count <= DEPTH), 32'h1);
      end
      check("stall_req_drop", {31'h0, imem_req_valid}, 32'h0);
      base = pop_count;
      inst_ready = 1'b1;
      repeat (20) tick();
      check("stall_resume", 32'(pop_count - base >= 10), 32'h1);

      // Redirect with two requests outstanding.
      do_reset();
      min_lat = 3;
      max_lat = 3;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 20 && pend.size() != 2; i++) tick();
      check("two_outstanding", 32'(pend.size()), 32'd2);
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 40 && !inst_valid; i++) tick();
      check("redir_head_valid", {31'h0, inst_valid}, 32'h1);
      check("redir_head_pc", inst_pc, 32'h100);
      check("redir_head_code", instruction_code, mem_word(32'h100));
      repeat (10) tick();

      // Access fault on the word at 0x8.
      do_reset();
      min_lat = 1;
      max_lat = 1;
      err_en = 1'b1;
      err_addr = 32'h8;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 30 && !fetch_fault; i++) tick();
      check("err_fetch_fault", {31'h0, fetch_fault}, 32'h1);
      check("err_fault_pc", fault_pc, 32'h8);
      check("err_delivered", 32'(pop_count), 32'd2);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("err_no_req", {31'h0, imem_req_valid}, 32'h0);
         check("err_sticky", {31'h0, fetch_fault}, 32'h1);
      end
      applyStimulus(1'b1, 32'h20, 1'b1, 1'b1);
      tick();
      redirect_valid = 1'b0;
      check("err_cleared", {31'h0, fetch_fault}, 32'h0);
      for (int i = 0; i < 30 && !inst_valid; i++) tick();
      check("err_recover_valid", {31'h0, inst_valid}, 32'h1);
      check("err_recover_pc", inst_pc, 32'h20);
      repeat (5) tick();
      err_en = 1'b0;

      // Asynchronous reset with the buffer full.
      do_reset();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (8) tick();
      check("full_before_reset", 32'(req_total - pop_count), 32'(DEPTH));
      check("none_in_flight", 32'(pend.size()), 32'd0);
      check("full_head_valid", {31'h0, inst_valid}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("async_inst_valid", {31'h0, inst_valid}, 32'h0);
      check("async_code", instruction_code, 32'h0);
      check("async_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("async_fault", {31'h0, fetch_fault}, 32'h0);
      check("async_inst_pc", inst_pc, RESET_PC);
      do_reset();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 20 && !inst_valid; i++) tick();
      check("restart_valid", {31'h0, inst_valid}, 32'h1);
      check("restart_pc", inst_pc, RESET_PC);

      // Randomized traffic with redirects and random memory/decode timing.
      do_reset();
      base = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            min_lat = 1;
            max_lat = $urandom_range(4, 1);
         end
         imem_req_ready = ($urandom_range(3, 0) != 0);
         inst_ready = ($urandom_range(3, 0) != 0);
         redirect_valid = ($urandom_range(24, 0) == 0);
         redirect_pc = 32'($urandom_range(1023, 0)) << 2;
         tick();
      end
      redirect_valid = 1'b0;
      check("random_progress", 32'(pop_count >= 300), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
